// File: rtl/uart_tx_frame_if.sv
// Client-to-transmitter handshake bundle for uart_tx_frame.
// The client (master) offers a word with valid/data; the transmitter (slave)
// answers with ready, drives the serial line tx and reports busy.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 tx;
   logic                 busy;

   modport master (
      output data,
      output valid,
      input  ready,
      input  tx,
      input  busy
   );

   modport slave (
      input  data,
      input  valid,
      output ready,
      output tx,
      output busy
   );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload bits in the
// chosen order, optional even/odd parity bit, 1 or 2 stop bits. The word is
// captured on the accept cycle, so the client may change data afterwards.
module uart_tx_frame #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY       = 0,  // 0 none, 1 even, 2 odd
   parameter int STOP_BITS    = 1,
   parameter int MSB_FIRST    = 0
) (
   input logic           clk,
   input logic           rst_n,
   uart_tx_frame_if.slave uart
);

   // Parameter legality is checked once at elaboration.
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_frame: DATA_BITS must be 5..9");
   end
   if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 1");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end
   if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_msb_first
      $error("uart_tx_frame: MSB_FIRST must be 0 or 1");
   end

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;      // data-bit index, reused for stop bits
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;      // running parity of bits sent so far
   logic                 tx_q, tx_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;

   logic                 baud_tick;
   logic                 next_bit;
   logic [DATA_BITS-1:0] shift_next;

   assign baud_tick  = (baud_q == BAUD_LAST);
   assign next_bit   = (MSB_FIRST != 0) ? shift_q[DATA_BITS-1] : shift_q[0];
   assign shift_next = (MSB_FIRST != 0) ? {shift_q[DATA_BITS-2:0], 1'b0}
                                        : {1'b0, shift_q[DATA_BITS-1:1]};

   // State register and all datapath registers; reset abandons any frame.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and next-output logic; each bit advances on the baud tick.
   // NOTE: every signal gets a hold default before the case, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      ready_d = ready_q;
      busy_d  = busy_q;

      if (state_q != S_IDLE) begin
         baud_d = baud_tick ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (uart.valid && ready_q) begin
               shift_d = uart.data;
               par_d   = (PARITY == 2);
               baud_d  = '0;
               tx_d    = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end

         S_START: begin
            if (baud_tick) begin
               tx_d    = next_bit;
               par_d   = par_q ^ next_bit;
               shift_d = shift_next;
               bit_d   = '0;
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            if (baud_tick) begin
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     tx_d    = par_q;
                     state_d = S_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_STOP;
                  end
               end else begin
                  tx_d    = next_bit;
                  par_d   = par_q ^ next_bit;
                  shift_d = shift_next;
                  bit_d   = bit_q + 1'b1;
               end
            end
         end

         S_PARITY: begin
            if (baud_tick) begin
               tx_d    = 1'b1;
               bit_d   = '0;
               state_d = S_STOP;
            end
         end

         S_STOP: begin
            if (baud_tick) begin
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  tx_d    = 1'b1;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign uart.tx    = tx_q;
   assign uart.ready = ready_q;
   assign uart.busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frames on four fixed configurations and
// a receiver model listening to 36 randomly fed configurations.
module tb_uart_tx_frame;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic rand_go = 1'b0;
   int   rand_done = 0;

   // Directed instances: A defaults, B even parity, C odd parity,
   // D 7 bits MSB first, 2 stop bits, one clk per bit.
   uart_tx_frame_if #(.DATA_BITS(8)) if_a ();
   uart_tx_frame_if #(.DATA_BITS(8)) if_b ();
   uart_tx_frame_if #(.DATA_BITS(8)) if_c ();
   uart_tx_frame_if #(.DATA_BITS(7)) if_d ();

   uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0))
      u_a (.clk(clk), .rst_n(rst_n), .uart(if_a));
   uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0))
      u_b (.clk(clk), .rst_n(rst_n), .uart(if_b));
   uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .MSB_FIRST(0))
      u_c (.clk(clk), .rst_n(rst_n), .uart(if_c));
   uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2), .MSB_FIRST(1))
      u_d (.clk(clk), .rst_n(rst_n), .uart(if_d));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int sel, input logic v, input logic [15:0] d);
      case (sel)
         0: begin if_a.valid = v; if_a.data = d[7:0]; end
         1: begin if_b.valid = v; if_b.data = d[7:0]; end
         2: begin if_c.valid = v; if_c.data = d[7:0]; end
         default: begin if_d.valid = v; if_d.data = d[6:0]; end
      endcase
   endtask

   // {tx, ready, busy} of a directed instance.
   function automatic logic [2:0] get_st(input int sel);
      case (sel)
         0: return {if_a.tx, if_a.ready, if_a.busy};
         1: return {if_b.tx, if_b.ready, if_b.busy};
         2: return {if_c.tx, if_c.ready, if_c.busy};
         default: return {if_d.tx, if_d.ready, if_d.busy};
      endcase
   endfunction

   // Reference frame: bits[i] is the line level during bit time i.
   function automatic void build_frame(input logic [15:0] d, input int db, input int par,
                                       input int stop, input int msb,
                                       output logic [15:0] bits, output int len);
      int ones;
      bits = '1;
      len  = 0;
      bits[len] = 1'b0;
      len++;
      for (int i = 0; i < db; i++) begin
         bits[len] = d[(msb != 0) ? (db - 1 - i) : i];
         len++;
      end
      ones = 0;
      for (int i = 0; i < db; i++) ones += int'(d[i]);
      if (par != 0) begin
         bits[len] = (par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
         len++;
      end
      for (int s = 0; s < stop; s++) begin
         bits[len] = 1'b1;
         len++;
      end
   endfunction

   // Offer one word, watch the whole frame cycle by cycle, then the idle cycle.
   task automatic run_frame(input string tag, input int sel, input logic [15:0] d,
                            input int cpb, input logic [15:0] exp_bits, input int len,
                            output logic [15:0] got);
      int         mism;
      int         busy_cnt;
      logic [2:0] st;
      @(posedge clk);
      #1 set_in(sel, 1'b1, d);
      @(posedge clk);
      #1 set_in(sel, 1'b0, ~d);
      mism = 0;
      busy_cnt = 0;
      got = '1;
      for (int c = 0; c < len * cpb; c++) begin
         @(negedge clk);
         st = get_st(sel);
         if (st[2] !== exp_bits[c / cpb]) mism++;
         if (st[0] === 1'b1) busy_cnt++;
         if ((c % cpb) == (cpb / 2)) got[c / cpb] = st[2];
      end
      @(negedge clk);
      st = get_st(sel);
      check({tag, " line mismatches"}, mism, 0);
      check({tag, " busy cycles"}, busy_cnt, len * cpb);
      check({tag, " idle {tx,ready,busy}"}, st, 3'b110);
   endtask

   // Randomised configurations, each with its own receiver model.
   for (genvar g = 0; g < 36; g++) begin : g_rnd
      localparam int PAR  = g % 3;
      localparam int STOP = 1 + (g / 3) % 2;
      localparam int MSB  = (g / 6) % 2;
      localparam int CPB  = (g < 12) ? 1 : (g < 24) ? 3 : 16;
      localparam int DB   = 5 + (g % 5);

      uart_tx_frame_if #(.DATA_BITS(DB)) bus ();
      uart_tx_frame #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(PAR),
                      .STOP_BITS(STOP), .MSB_FIRST(MSB))
         u_dut (.clk(clk), .rst_n(rst_n), .uart(bus));

      initial begin
         logic [DB-1:0] word;
         logic [DB-1:0] rx_word;
         logic          pbit;
         logic          frame_ok;
         logic          par_ok;
         int            ones;
         int            to;
         bus.valid = 1'b0;
         bus.data  = '0;
         wait (rand_go);
         for (int k = 0; k < 8; k++) begin
            word = DB'($urandom);
            to = 0;
            while (bus.ready !== 1'b1 && to < 500) begin
               @(negedge clk);
               to++;
            end
            @(posedge clk);
            #1 bus.valid = 1'b1;
            bus.data = word;
            to = 0;
            do begin
               @(negedge clk);
               to++;
            end while (bus.tx !== 1'b0 && to < 8);
            bus.valid = 1'b0;
            bus.data  = ~word;
            // Line fell: sample each bit at its centre.
            repeat (CPB / 2) @(negedge clk);
            frame_ok = (bus.tx === 1'b0);
            rx_word  = '0;
            for (int i = 0; i < DB; i++) begin
               repeat (CPB) @(negedge clk);
               if (MSB != 0) rx_word[DB - 1 - i] = bus.tx;
               else          rx_word[i] = bus.tx;
            end
            pbit = 1'b0;
            if (PAR != 0) begin
               repeat (CPB) @(negedge clk);
               pbit = bus.tx;
            end
            for (int s = 0; s < STOP; s++) begin
               repeat (CPB) @(negedge clk);
               frame_ok = frame_ok & (bus.tx === 1'b1);
            end
            ones = $countones(rx_word) + int'(pbit);
            par_ok = (PAR == 0) || ((ones % 2) == ((PAR == 2) ? 1 : 0));
            check($sformatf("rx cfg%0d word%0d {framing,parity,data}", g, k),
                  {frame_ok, par_ok, rx_word}, {1'b1, 1'b1, word});
         end
         rand_done++;
      end
   end

   initial begin
      logic [15:0] eb;
      logic [15:0] eb2;
      logic [15:0] got;
      int          len;
      int          len2;
      int          mism;
      int          rise1;
      int          fall2;
      logic        exp_l;
      logic        line [0:90];

      for (int s = 0; s < 4; s++) set_in(s, 1'b0, 16'h0);

      // Reset state.
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 4; s++) check($sformatf("reset inst%0d {tx,ready,busy}", s), get_st(s), 3'b110);
      #1 rst_n = 1'b1;

      // Defaults, 8'hA5, LSB first, no parity.
      run_frame("t1 A5", 0, 16'h00A5, 4, {6'h3F, 10'b1101001010}, 10, got);

      // Even and odd parity.
      build_frame(16'h00A5, 8, 1, 1, 0, eb, len);
      run_frame("t2 even A5", 1, 16'h00A5, 4, eb, len, got);
      check("t2 even A5 parity bit", got[9], 1'b0);
      build_frame(16'h00A5, 8, 2, 1, 0, eb, len);
      run_frame("t2 odd A5", 2, 16'h00A5, 4, eb, len, got);
      check("t2 odd A5 parity bit", got[9], 1'b1);
      build_frame(16'h0001, 8, 1, 1, 0, eb, len);
      run_frame("t2 even 01", 1, 16'h0001, 4, eb, len, got);
      check("t2 even 01 parity bit", got[9], 1'b1);

      // 7 bits, MSB first, 2 stop bits, 1 clk per bit.
      run_frame("t3 41", 3, 16'h0041, 1, {6'h3F, 10'b1110000010}, 10, got);

      // Back-to-back with valid held, data changes and a mid-frame valid pulse.
      build_frame(16'h0055, 8, 0, 1, 0, eb, len);
      build_frame(16'h00AA, 8, 0, 1, 0, eb2, len2);
      @(posedge clk);
      #1 set_in(0, 1'b1, 16'h0055);
      @(posedge clk);
      #1 set_in(0, 1'b1, 16'h00AA);
      for (int c = 0; c <= 90; c++) begin
         @(negedge clk);
         line[c] = if_a.tx;
         if (c == 41) set_in(0, 1'b0, 16'h00AA);
         if (c == 50) set_in(0, 1'b0, 16'h0000);
         if (c == 60) set_in(0, 1'b1, 16'h0000);
         if (c == 61) set_in(0, 1'b0, 16'h0000);
      end
      mism = 0;
      for (int c = 0; c <= 90; c++) begin
         if (c < 40)      exp_l = eb[c / 4];
         else if (c < 41) exp_l = 1'b1;
         else if (c < 81) exp_l = eb2[(c - 41) / 4];
         else             exp_l = 1'b1;
         if (line[c] !== exp_l) mism++;
      end
      check("t4 back-to-back line mismatches", mism, 0);
      rise1 = -1;
      for (int c = 1; c < 40; c++) if (line[c] === 1'b1 && line[c-1] === 1'b0) rise1 = c;
      fall2 = -1;
      for (int c = 90; c >= 40; c--) if (line[c] === 1'b0 && line[c-1] === 1'b1 && c < 60) fall2 = c;
      check("t4 stop-begin to next start", fall2 - rise1, 5);
      check("t4 no extra frame {tx,ready,busy}", get_st(0), 3'b110);

      // Reset during the third data bit.
      @(posedge clk);
      #1 set_in(0, 1'b1, 16'h0000);
      @(posedge clk);
      #1 set_in(0, 1'b0, 16'h0000);
      for (int c = 0; c <= 12; c++) @(negedge clk);
      check("t5 line low before reset", if_a.tx, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5 mid-frame reset {tx,ready,busy}", get_st(0), 3'b110);
      rst_n = 1'b1;
      build_frame(16'h00C3, 8, 0, 1, 0, eb, len);
      run_frame("t5 C3 after reset", 0, 16'h00C3, 4, eb, len, got);

      // Randomised configurations.
      rand_go = 1'b1;
      for (int t = 0; t < 20000 && rand_done < 36; t++) @(negedge clk);
      check("random configurations finished", rand_done, 36);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
